bitmap_scanout: RTL

- Video fetch stage that sits directly downstream of the synchronous video RAM (one-clock read latency, registered dout) in the VGA test design.
- Takes raster position from the sync generator, schedules byte reads of a 1 bpp framebuffer, and prefetches one byte ahead to hide RAM latency.
- Serialises each byte MSB-first into a registered 3-bit RGB pixel stream.
- Read-only: never drives RAM write enable.

---
 rtl/bitmap_scanout.sv | 94 +++++++++
 1 files changed

// File: rtl/bitmap_scanout.sv
// Video fetch stage for a 1 bpp framebuffer behind a one-clock-latency sync RAM.
// Prefetches each byte one step ahead and serialises it MSB-first onto a registered RGB stream.
module bitmap_scanout #(
  parameter int         A        = 13,
  parameter int         H_BYTES  = 32,
  parameter int         H_TOTAL  = 309,
  parameter int         V_ACTIVE = 240,
  parameter int         V_TOTAL  = 262,
  parameter logic [2:0] FG       = 3'b111,
  parameter logic [2:0] BG       = 3'b000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [8:0]   hpos,
  input  logic [8:0]   vpos,
  output logic [A-1:0] ram_addr,
  input  logic [7:0]   ram_dout,
  output logic [2:0]   rgb
);

  localparam int         H_ACTIVE   = 8 * H_BYTES;
  localparam logic [8:0] H_ACT_END  = 9'(H_ACTIVE);
  localparam logic [8:0] H_PREFETCH = 9'(H_TOTAL - 3);
  localparam logic [8:0] H_LAST     = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_ACT_END  = 9'(V_ACTIVE);
  localparam logic [8:0] V_LAST_VIS = 9'(V_ACTIVE - 1);
  localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
  localparam logic [5:0] LAST_COL   = 6'(H_BYTES - 1);
  localparam logic [A-1:0] STRIDE   = A'(H_BYTES);

  logic         active;
  logic         next_line_active;
  logic [5:0]   col;
  logic         col_fetch;
  logic         col_load;
  logic [A-1:0] base;
  logic [A-1:0] col_addr;
  logic [7:0]   shreg;

  assign active           = (hpos < H_ACT_END) && (vpos < V_ACT_END);
  assign col              = hpos[8:3];
  assign next_line_active = (vpos == V_LAST) || (vpos < V_LAST_VIS);
  // Fetch the next column's byte two cycles before it is needed; the last column was prefetched already.
  assign col_fetch        = active && (hpos[2:0] == 3'd5) && (col < LAST_COL);
  assign col_load         = active && (hpos[2:0] == 3'd7) && (col < LAST_COL);
  assign col_addr         = base + A'(col) + A'(1);

  // Base of the line the next prefetch targets; advanced once the current line's fetches are done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base <= '0;
    end else if (hpos == H_ACT_END) begin
      if (vpos == V_LAST) begin
        base <= '0;
      end else if (vpos < V_LAST_VIS) begin
        base <= base + STRIDE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_addr <= '0;
    end else if ((hpos == H_PREFETCH) && next_line_active) begin
      ram_addr <= base;
    end else if (col_fetch) begin
      ram_addr <= col_addr;
    end
  end

  // Load wins over shift so the first pixel of each byte is ready on the next column's first cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
    end else if ((hpos == H_LAST) && next_line_active) begin
      shreg <= ram_dout;
    end else if (col_load) begin
      shreg <= ram_dout;
    end else if (active) begin
      shreg <= {shreg[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb <= 3'b000;
    end else if (active) begin
      rgb <= shreg[7] ? FG : BG;
    end else begin
      rgb <= 3'b000;
    end
  end

endmodule
